coherence_bus_ctrl: RTL and testbench

Snooping MESI bus controller for two private L1 data caches; it drives the coherency_unit side of each cache's cache_coherence_if.
- Arbitrates cache misses, snoops the peer cache and sources each block from the peer or from memory.
- Writes back dirty peer data when the request is a read miss.
- Issues the final cc_end_state to both caches.
- Sits between the L1 caches and the memory controller.

---
 rtl/coherence_pkg.sv | 35 +++
 rtl/rr_arbiter_2.sv | 29 ++
 rtl/coherence_bus_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coherence_pkg.sv
// Shared types and default cache geometry for the two-cache MESI snooping bus controller.
package coherence_pkg;

    localparam int DEFAULT_CACHE_SIZE = 1024;
    localparam int DEFAULT_ASSOC      = 1;
    localparam int DEFAULT_BLOCK_SIZE = 2;

    localparam int N_SETS = DEFAULT_CACHE_SIZE / 8 / 4 / DEFAULT_BLOCK_SIZE / DEFAULT_ASSOC;
    localparam int SB     = $clog2(N_SETS);
    localparam int BB     = $clog2(DEFAULT_BLOCK_SIZE);
    localparam int TB     = 32 - SB - BB - 2;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        MODIFIED  = 2'd0,
        EXCLUSIVE = 2'd1,
        SHARED    = 2'd2,
        INVALID   = 2'd3
    } cc_end_state_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SNOOP  = 3'd1,
        C2C    = 3'd2,
        MEM_RD = 3'd3,
        DONE   = 3'd4
    } bus_state_t;

    // A single-word block still needs a one-bit word select.
    function automatic int word_sel_width(input int bb);
        return (bb > 0) ? bb : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: the pointer breaks ties and moves to the other cache after each grant.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       done_idx,
    output logic [1:0] grant
);

    logic ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (advance) begin
            ptr_q <= ~done_idx;
        end
    end

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant        = 2'b00;
            grant[ptr_q] = 1'b1;
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snooping MESI bus controller for two L1 caches: arbitrates misses, snoops the peer,
// sources the block cache-to-cache or from memory, and issues the final MESI states.
module coherence_bus_ctrl
    import coherence_pkg::*;
#(
    parameter  int CACHE_SIZE = DEFAULT_CACHE_SIZE,
    parameter  int ASSOC      = DEFAULT_ASSOC,
    parameter  int BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
    localparam int SETS       = CACHE_SIZE / 8 / 4 / BLOCK_SIZE / ASSOC,
    localparam int SET_W      = $clog2(SETS),
    localparam int OFF_W      = $clog2(BLOCK_SIZE),
    localparam int TAG_W      = 32 - SET_W - OFF_W - 2,
    localparam int WSEL_W     = word_sel_width(OFF_W)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [1:0]             cache_req,
    input  logic [1:0]             cache_write,
    input  logic [1:0][31:0]       cache_addr,
    output logic [1:0]             cache_grant,
    output logic [1:0][1:0]        state_transfer,
    output logic [1:0]             state_valid,
    output logic [SET_W-1:0]       set_sel,
    output logic [TAG_W-1:0]       snoop_tag,
    output logic [WSEL_W-1:0]      word_sel,
    output logic [1:0]             snoop_req,
    input  logic [1:0]             snoop_hit,
    input  logic [1:0]             dirty,
    input  logic [1:0][31:0]       requested_data,
    output word_t                  responder_data,
    output logic [1:0]             fill_valid,
    output logic                   mem_ren,
    output logic                   mem_wen,
    output word_t                  mem_addr,
    output word_t                  mem_wdata,
    input  word_t                  mem_rdata,
    input  logic                   mem_ready,
    output bus_state_t             dbg_state
);

    localparam logic [WSEL_W-1:0] LAST_WORD  = WSEL_W'(BLOCK_SIZE - 1);
    localparam word_t             BLOCK_MASK = word_t'(BLOCK_SIZE * 4 - 1);

    bus_state_t        state, state_n;
    logic              req_idx;
    logic              wr_q;
    logic              hit_q;
    logic              dirty_q;
    word_t             base_q;
    logic [WSEL_W-1:0] word_q;
    logic [1:0]        arb_grant;
    logic              peer;
    logic              last_word;
    logic              word_adv;
    logic              writeback;
    word_t             word_addr;

    assign peer      = ~req_idx;
    assign last_word = (word_q == LAST_WORD);
    // Dirty data is only pushed to memory when the peer keeps a SHARED copy.
    assign writeback = ~wr_q & dirty_q;
    assign word_addr = base_q + (word_t'(word_q) << 2);
    assign dbg_state = state;

    rr_arbiter_2 u_arb (
        .clk      (CLK),
        .rst_n    (nRST),
        .req      (cache_req),
        .advance  (state == DONE),
        .done_idx (req_idx),
        .grant    (arb_grant)
    );

    always_comb begin
        word_adv = 1'b0;
        case (state)
            C2C:     word_adv = writeback ? mem_ready : 1'b1;
            MEM_RD:  word_adv = mem_ready;
            default: word_adv = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_idx <= 1'b0;
            wr_q    <= 1'b0;
            hit_q   <= 1'b0;
            dirty_q <= 1'b0;
            base_q  <= '0;
            word_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|cache_req) begin
                        req_idx <= arb_grant[1];
                        wr_q    <= cache_write[arb_grant[1]];
                        base_q  <= cache_addr[arb_grant[1]] & ~BLOCK_MASK;
                    end
                end
                SNOOP: begin
                    hit_q   <= snoop_hit[peer];
                    dirty_q <= dirty[peer];
                end
                C2C, MEM_RD: begin
                    if (word_adv) begin
                        word_q <= last_word ? '0 : word_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n        = state;
        cache_grant    = 2'b00;
        state_transfer = {INVALID, INVALID};
        state_valid    = 2'b00;
        set_sel        = '0;
        snoop_tag      = '0;
        word_sel       = '0;
        snoop_req      = 2'b00;
        responder_data = '0;
        fill_valid     = 2'b00;
        mem_ren        = 1'b0;
        mem_wen        = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        if (state != IDLE) begin
            set_sel   = base_q[2+OFF_W +: SET_W];
            snoop_tag = base_q[31 -: TAG_W];
            word_sel  = word_q;
        end

        case (state)
            IDLE: begin
                if (|cache_req) begin
                    state_n = SNOOP;
                end
            end
            SNOOP: begin
                snoop_req[peer] = 1'b1;
                state_n         = snoop_hit[peer] ? C2C : MEM_RD;
            end
            C2C: begin
                snoop_req[peer]     = 1'b1;
                responder_data      = requested_data[peer];
                fill_valid[req_idx] = word_adv;
                if (writeback) begin
                    mem_wen   = 1'b1;
                    mem_addr  = word_addr;
                    mem_wdata = requested_data[peer];
                end
                if (word_adv && last_word) begin
                    state_n = DONE;
                end
            end
            MEM_RD: begin
                mem_ren  = 1'b1;
                mem_addr = word_addr;
                if (mem_ready) begin
                    responder_data      = mem_rdata;
                    fill_valid[req_idx] = 1'b1;
                end
                if (word_adv && last_word) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                cache_grant[req_idx] = 1'b1;
                state_valid[req_idx] = 1'b1;
                if (wr_q) begin
                    state_transfer[req_idx] = MODIFIED;
                end else if (hit_q) begin
                    state_transfer[req_idx] = SHARED;
                end else begin
                    state_transfer[req_idx] = EXCLUSIVE;
                end
                if (hit_q) begin
                    state_valid[peer]    = 1'b1;
                    state_transfer[peer] = wr_q ? INVALID : SHARED;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Randomized scoreboard bench for coherence_bus_ctrl with peer-cache and memory models.
module tb_coherence_bus_ctrl;
    import coherence_pkg::*;

    localparam int BS  = DEFAULT_BLOCK_SIZE;
    localparam int WSW = (BB > 0) ? BB : 1;
    localparam int SNW = 2 + SB + TB;

    // clock / reset and DUT signals
    logic              CLK = 1'b0;
    logic              nRST;
    logic [1:0]        cache_req, cache_write, cache_grant, state_valid;
    logic [1:0]        snoop_req, snoop_hit, dirty, fill_valid;
    logic [1:0][31:0]  cache_addr, requested_data;
    logic [1:0][1:0]   state_transfer;
    logic [SB-1:0]     set_sel;
    logic [TB-1:0]     snoop_tag;
    logic [WSW-1:0]    word_sel;
    word_t             responder_data, mem_addr, mem_wdata, mem_rdata;
    logic              mem_ren, mem_wen, mem_ready;
    bus_state_t        dbg_state;

    always #5 CLK = ~CLK;

    coherence_bus_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .cache_req(cache_req), .cache_write(cache_write), .cache_addr(cache_addr),
        .cache_grant(cache_grant), .state_transfer(state_transfer), .state_valid(state_valid),
        .set_sel(set_sel), .snoop_tag(snoop_tag), .word_sel(word_sel),
        .snoop_req(snoop_req), .snoop_hit(snoop_hit), .dirty(dirty),
        .requested_data(requested_data), .responder_data(responder_data),
        .fill_valid(fill_valid), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .dbg_state(dbg_state)
    );

    // scoreboard state
    int n_cmp  = 0;
    int n_fail = 0;
    logic [40:0]    fill_q[$];   // {cache, word, data}
    logic [64:0]    mem_q[$];    // {is_write, addr, data (writes only)}
    logic [6:0]     done_q[$];   // {req, req_valid, req_state, peer_valid, peer_state}
    logic [SNW-1:0] snp_q[$];    // {snoop_req, set, tag}

    // peer-cache behaviour when snooped, memory contents, arbitration model
    bit    cfg_hit[2];
    bit    cfg_dirty[2];
    word_t cfg_data[2][BS];
    word_t dev_mem[word_t];
    word_t ref_mem[word_t];
    bit    ptr_m;
    bit    slow_w1;

    function automatic word_t dflt(input word_t a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input logic [95:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got 0x%0h expected nothing", name, act);
    endtask

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            snoop_hit[c]      = snoop_req[c] & cfg_hit[c];
            dirty[c]          = snoop_req[c] & cfg_hit[c] & cfg_dirty[c];
            requested_data[c] = cfg_data[c][word_sel];
        end
    end

    // memory model: random wait per access, or word 0 immediate / word 1 after 5 idle cycles in slow mode
    initial begin
        int  wait_cnt;
        bit  have_wait;
        mem_ready = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        have_wait = 1'b0;
        forever begin
            @(negedge CLK);
            if (!nRST || !(mem_ren || mem_wen)) begin
                mem_ready = 1'b0;
                have_wait = 1'b0;
                mem_rdata = $urandom;
            end else begin
                if (!have_wait || mem_ready) begin
                    if (slow_w1) wait_cnt = (word_sel == 1) ? 5 : 0;
                    else         wait_cnt = $urandom_range(0, 2);
                    have_wait = 1'b1;
                end
                if (wait_cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : dflt(mem_addr);
                    if (mem_wen) dev_mem[mem_addr] = mem_wdata;
                end else begin
                    wait_cnt--;
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // monitor: pops the scoreboard whenever the DUT presents a fill, memory beat, snoop or grant
    initial begin
        logic [1:0] prev_snoop;
        bit         gi;
        prev_snoop = 2'b00;
        forever begin
            @(negedge CLK);
            #1;
            if (nRST) begin
                if (fill_valid != 2'b00) begin
                    check("fill_onehot", $countones(fill_valid), 1);
                    if (fill_q.size() == 0) fail_evt("fill_unexpected", {fill_valid, responder_data});
                    else check("fill", {fill_valid[1], 8'(word_sel), responder_data}, fill_q.pop_front());
                end
                if (mem_ren && mem_wen) fail_evt("mem_ren_and_wen", 2'b11);
                if (mem_ren || mem_wen) begin
                    check("fill_gated_by_mem_ready", fill_valid != 2'b00, mem_ready);
                    if (slow_w1 && !mem_ready) check("stall_word_sel", word_sel, 1);
                    if (mem_ready) begin
                        if (mem_q.size() == 0) fail_evt("mem_unexpected", {mem_wen, mem_addr});
                        else check("mem_access", {mem_wen, mem_addr, mem_wen ? mem_wdata : 32'h0},
                                   mem_q.pop_front());
                    end
                end
                if (snoop_req != 2'b00 && prev_snoop == 2'b00) begin
                    if (snp_q.size() == 0) fail_evt("snoop_unexpected", snoop_req);
                    else check("snoop", {snoop_req, set_sel, snoop_tag}, snp_q.pop_front());
                end
                if (cache_grant != 2'b00) begin
                    check("grant_onehot", $countones(cache_grant), 1);
                    gi = cache_grant[1];
                    if (done_q.size() == 0) fail_evt("grant_unexpected", cache_grant);
                    else check("done_states", {gi, state_valid[gi], state_transfer[gi], state_valid[!gi],
                                               state_valid[!gi] ? state_transfer[!gi] : 2'b00},
                               done_q.pop_front());
                end else if (state_valid != 2'b00) begin
                    fail_evt("state_valid_without_grant", state_valid);
                end
            end
            prev_snoop = nRST ? snoop_req : 2'b00;
        end
    end

    task automatic set_peer(input int c, input bit hit, input bit d);
        cfg_hit[c]   = hit;
        cfg_dirty[c] = d;
        for (int w = 0; w < BS; w++) cfg_data[c][w] = $urandom;
    endtask

    // reference model of one transaction, derived from the MESI rules
    task automatic push_expect(input bit r, input bit wr, input word_t addr);
        bit         p, hit, wb;
        word_t      base, a, d;
        logic [1:0] st_r, st_p;
        p    = !r;
        base = addr - (addr % (BS * 4));
        hit  = cfg_hit[p];
        wb   = hit && !wr && cfg_dirty[p];
        snp_q.push_back({(p ? 2'b10 : 2'b01), SB'((base >> (2 + BB)) % N_SETS), TB'(base >> (32 - TB))});
        for (int w = 0; w < BS; w++) begin
            a = base + word_t'(4 * w);
            if (hit) begin
                d = cfg_data[p][w];
                if (wb) begin
                    mem_q.push_back({1'b1, a, d});
                    ref_mem[a] = d;
                end
            end else begin
                d = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
                mem_q.push_back({1'b0, a, 32'h0});
            end
            fill_q.push_back({r, 8'(w), d});
        end
        st_r = wr ? 2'(MODIFIED) : (hit ? 2'(SHARED) : 2'(EXCLUSIVE));
        st_p = hit ? (wr ? 2'(INVALID) : 2'(SHARED)) : 2'b00;
        done_q.push_back({r, 1'b1, st_r, hit, st_p});
    endtask

    task automatic run_txn(input bit r, input bit wr, input word_t addr, output int lat);
        push_expect(r, wr, addr);
        @(negedge CLK);
        #2;
        cache_write[r] = wr;
        cache_addr[r]  = addr;
        cache_req[r]   = 1'b1;
        lat = 0;
        while (!cache_grant[r] && lat < 300) begin
            @(negedge CLK);
            #2;
            lat++;
        end
        if (lat >= 300) fail_evt("grant_timeout", r);
        cache_req[r] = 1'b0;
        ptr_m = !r;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"}, {cache_grant, state_valid, snoop_req, fill_valid, mem_ren, mem_wen}, 0);
        check({tag, "_sel"}, {set_sel, snoop_tag, word_sel}, 0);
        check({tag, "_data"}, {responder_data, mem_addr, mem_wdata}, 0);
        check({tag, "_state_transfer"}, state_transfer, {2'(INVALID), 2'(INVALID)});
    endtask

    initial begin
        int  lat, n, k;
        bit  r, wr, hit, d, w;
        word_t addr;

        nRST        = 1'b1;
        cache_req   = 2'b00;
        cache_write = 2'b00;
        cache_addr  = '0;
        slow_w1     = 1'b0;
        ptr_m       = 1'b0;
        set_peer(0, 0, 0);
        set_peer(1, 0, 0);
        #1 nRST = 1'b0;
        #2;
        check_idle_outputs("reset");
        check("reset_dbg_state", dbg_state, IDLE);
        repeat (3) @(negedge CLK);
        #2 nRST = 1'b1;

        // cache0 read miss, peer misses: block from memory, EXCLUSIVE
        set_peer(1, 0, 0);
        run_txn(0, 0, 32'h0000_0040, lat);

        // cache1 read miss, cache0 dirty hit: writeback plus fill, both SHARED
        set_peer(0, 1, 1);
        cfg_data[0][0] = 32'h0000_000A;
        cfg_data[0][1] = 32'h0000_000B;
        run_txn(1, 0, 32'h0000_0120, lat);

        // cache0 write miss, cache1 clean hit: no memory traffic, fixed latency
        set_peer(1, 1, 0);
        run_txn(0, 1, 32'h0000_0080, lat);
        check("c2c_latency", lat, 2 + BS);

        // dirty writeback with word 1 stalled by memory
        set_peer(0, 1, 1);
        slow_w1 = 1'b1;
        run_txn(1, 0, 32'h0000_0200, lat);
        slow_w1 = 1'b0;

        // asynchronous reset in the middle of a memory read, word 1
        set_peer(1, 0, 0);
        slow_w1 = 1'b1;
        push_expect(0, 0, 32'h0000_0300);
        @(negedge CLK);
        #2;
        cache_addr[0]  = 32'h0000_0300;
        cache_write[0] = 1'b0;
        cache_req[0]   = 1'b1;
        n = 0;
        while (!(mem_ren && word_sel == 1 && !mem_ready) && n < 100) begin
            @(negedge CLK);
            #2;
            n++;
        end
        if (n >= 100) fail_evt("reset_wait_timeout", n);
        nRST = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        cache_req = 2'b00;
        fill_q.delete();
        mem_q.delete();
        done_q.delete();
        snp_q.delete();
        ptr_m   = 1'b0;
        slow_w1 = 1'b0;
        @(negedge CLK);
        #2 nRST = 1'b1;
        set_peer(0, 0, 0);
        run_txn(1, 0, 32'h0000_0304, lat);

        // both caches request continuously: grants alternate starting with cache 0
        set_peer(0, 0, 0);
        set_peer(1, 0, 0);
        cache_addr[0] = 32'h0000_0010;
        cache_addr[1] = 32'h0000_0350;
        cache_write   = 2'b10;
        for (int i = 0; i < 4; i++) begin
            w = ptr_m;
            push_expect(w, cache_write[w], cache_addr[w]);
            ptr_m = !w;
        end
        @(negedge CLK);
        #2;
        cache_req = 2'b11;
        k = 0;
        n = 0;
        while (k < 4 && n < 400) begin
            @(negedge CLK);
            #2;
            n++;
            if (cache_grant != 2'b00) begin
                check("rr_order", cache_grant[1], k % 2);
                k++;
            end
        end
        cache_req = 2'b00;
        if (k < 4) fail_evt("rr_timeout", k);

        // randomized traffic over a small address window so writebacks get read back
        for (int i = 0; i < 30; i++) begin
            r    = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            hit  = 1'($urandom_range(0, 1));
            d    = 1'($urandom_range(0, 1));
            set_peer(!r, hit, d);
            addr = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
            run_txn(r, wr, addr, lat);
        end

        repeat (4) @(negedge CLK);
        check("fill_q_drained", fill_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        check("snoop_q_drained", snp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
